cube_calc: RTL and testbench



---
 rtl/cube_pkg.sv | 25 ++
 rtl/shift_add_step.sv | 34 +++
 rtl/cube_calc.sv | 179 +++++++++++++++++
 tb/tb_cube_calc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// ============================================================================
// Module      : cube_pkg
// Description : Shared types and constants for the iterative integer cuber.
//               Holds the FSM state encoding, the default operand/result
//               widths and the number of shift-add iterations per pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cube_pkg;

    localparam int CUBE_XW    = 8;   // operand width
    localparam int CUBE_YW    = 24;  // result width (3 * CUBE_XW)
    localparam int CUBE_STEPS = 8;   // shift-add iterations per pass

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQR  = 2'd1,
        ST_CUB  = 2'd2,
        ST_DONE = 2'd3
    } cube_state_e;

endpackage : cube_pkg

`default_nettype wire

// File: rtl/shift_add_step.sv
// ============================================================================
// Module      : shift_add_step
// Description : One combinational shift-add multiplier iteration:
//               o_acc_next = i_acc + (i_bit ? i_mcand << i_step : 0)
// Ports       : i_acc      running partial product
//               i_mcand    multiplicand, zero-extended to YW bits
//               i_bit      current multiplier bit
//               i_step     bit position / shift amount
//               o_acc_next updated partial product
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_step #(
    parameter int YW = 24,
    parameter int SW = 4
) (
    input  logic [YW-1:0] i_acc,
    input  logic [YW-1:0] i_mcand,
    input  logic          i_bit,
    input  logic [SW-1:0] i_step,
    output logic [YW-1:0] o_acc_next
);

    logic [YW-1:0] w_addend;

    always_comb begin
        w_addend   = i_bit ? (i_mcand << i_step) : '0;
        o_acc_next = i_acc + w_addend;
    end

endmodule : shift_add_step

`default_nettype wire

// File: rtl/cube_calc.sv
// ============================================================================
// Module      : cube_calc
// Description : Iterative unsigned integer cuber, y = x^3. A single shared
//               shift-add step computes x*x in an 8-cycle SQR pass, then
//               x^2*x in an 8-cycle CUB pass, then publishes the result in a
//               one-cycle DONE state. Fixed latency of 17 cycles from the
//               accepted start to the done pulse.
// Ports       : clk    system clock (rising edge)
//               rst    synchronous active-high reset
//               start  request strobe, sampled only in IDLE
//               x_bi   operand, captured on the accepted start edge
//               busy   high while a computation is in flight
//               done   one-cycle pulse when y_bo updates
//               y_bo   result, held until next done or reset
//               step   iteration index      (only with CUBE_CALC_DEBUG_EN)
//               acc    running accumulator  (only with CUBE_CALC_DEBUG_EN)
// Config      : define CUBE_CALC_DEBUG_EN to expose step/acc debug ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_calc
    import cube_pkg::*;
#(
    parameter int XW = CUBE_XW,
    parameter int YW = CUBE_YW   // must equal 3*XW; x^3 then never overflows
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x_bi,
    output logic          busy,
    output logic          done,
    output logic [YW-1:0] y_bo
`ifdef CUBE_CALC_DEBUG_EN
    ,
    output logic [3:0]    step,
    output logic [YW-1:0] acc
`endif
);

    localparam int SW = 4;              // step counter width (debug port width)
    localparam int IW = $clog2(XW);     // bits needed to index the operand
    localparam logic [SW-1:0] LAST_STEP = SW'(CUBE_STEPS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    cube_state_e     r_state;
    logic [XW-1:0]   r_x;
    logic [2*XW-1:0] r_sq;
    logic [YW-1:0]   r_acc;
    logic [SW-1:0]   r_step;
    logic [YW-1:0]   r_y;
    logic            r_done;

    cube_state_e     w_state_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [2*XW-1:0] w_sq_nxt;
    logic [YW-1:0]   w_acc_nxt;
    logic [SW-1:0]   w_step_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic            w_done_nxt;

    // ------------------------------------------------------------------
    // Shared shift-add step. The multiplier is always x; the multiplicand
    // is x during the squaring pass and x^2 during the cubing pass.
    // ------------------------------------------------------------------
    logic [YW-1:0] w_mcand;
    logic          w_bit;
    logic [YW-1:0] w_acc_sum;

    assign w_mcand = (r_state == ST_SQR) ? YW'(r_x) : YW'(r_sq);
    assign w_bit   = r_x[r_step[IW-1:0]];

    shift_add_step #(
        .YW (YW),
        .SW (SW)
    ) u_step (
        .i_acc      (r_acc),
        .i_mcand    (w_mcand),
        .i_bit      (w_bit),
        .i_step     (r_step),
        .o_acc_next (w_acc_sum)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_sq    <= '0;
            r_acc   <= '0;
            r_step  <= '0;
            r_y     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_sq    <= w_sq_nxt;
            r_acc   <= w_acc_nxt;
            r_step  <= w_step_nxt;
            r_y     <= w_y_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_sq_nxt    = r_sq;
        w_acc_nxt   = r_acc;
        w_step_nxt  = r_step;
        w_y_nxt     = r_y;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_x_nxt     = x_bi;
                    w_acc_nxt   = '0;
                    w_step_nxt  = '0;
                    w_state_nxt = ST_SQR;
                end
            end

            ST_SQR: begin
                w_acc_nxt  = w_acc_sum;
                w_step_nxt = r_step + SW'(1);
                if (r_step == LAST_STEP) begin
                    // x^2 is complete; it becomes the multiplicand of pass two
                    w_sq_nxt    = w_acc_sum[2*XW-1:0];
                    w_acc_nxt   = '0;
                    w_step_nxt  = '0;
                    w_state_nxt = ST_CUB;
                end
            end

            ST_CUB: begin
                w_acc_nxt  = w_acc_sum;
                w_step_nxt = r_step + SW'(1);
                if (r_step == LAST_STEP) begin
                    w_step_nxt  = '0;
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                w_y_nxt     = r_acc;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign y_bo = r_y;

`ifdef CUBE_CALC_DEBUG_EN
    assign step = r_step;
    assign acc  = r_acc;
`endif

endmodule : cube_calc

`default_nettype wire

// File: tb/tb_cube_calc.sv
// ============================================================================
// Module      : tb_cube_calc
// Description : Directed self-checking bench for cube_calc. Each vector has a
//               hand-computed expected cube; latency, busy width and the
//               start/reset corner cases are checked explicitly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cube_calc;

    import cube_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  x_bi;
    logic        busy;
    logic        done;
    logic [23:0] y_bo;
`ifdef CUBE_CALC_DEBUG_EN
    logic [3:0]  dbg_step;
    logic [23:0] dbg_acc;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cube_calc #(
        .XW (8),
        .YW (24)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_bi  (x_bi),
        .busy  (busy),
        .done  (done),
        .y_bo  (y_bo)
`ifdef CUBE_CALC_DEBUG_EN
        ,
        .step  (dbg_step),
        .acc   (dbg_acc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int icbrt(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 256; k++)
            if (k * k * k <= v) r = k;
        return r;
    endfunction

    // Single operation: pulse start for one cycle, then measure latency,
    // busy width and result, and confirm done lasts one cycle.
    task automatic do_cube(input logic [7:0] xv, input logic [23:0] exp_y,
                           input string tag, input bit root_chk);
        int lat;
        int bcnt;
        bit got;
        @(negedge clk);
        start = 1'b1;
        x_bi  = xv;
        @(negedge clk);               // accepting edge E0 has passed
        start = 1'b0;
        x_bi  = 8'hA5;                // don't-care outside the accepting edge
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        while (!got && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        check({tag, "_lat"},  lat,  17);
        check({tag, "_y"},    y_bo, exp_y);
        check({tag, "_busy"}, bcnt, 17);
        if (root_chk)
            check({tag, "_root"}, icbrt(int'(y_bo)), int'(xv));
        @(negedge clk);
        check({tag, "_done1"}, {31'd0, done}, 0);
    endtask

    initial begin
        int dcnt;
        int d1;
        int d2;
        int cyc;
        logic [23:0] y1;
        logic [23:0] y2;

        rst   = 1'b1;
        start = 1'b0;
        x_bi  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_y",    y_bo, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);

        // Basic and extreme operands
        do_cube(8'd3,   24'd27,       "x3",   1'b0);
        do_cube(8'd0,   24'd0,        "x0",   1'b0);
        do_cube(8'd255, 24'hFD02FF,   "x255", 1'b0);
        do_cube(8'd1,   24'd1,        "x1",   1'b0);
        do_cube(8'd170, 24'd4913000,  "x170", 1'b0);

        // start pulse while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        x_bi  = 8'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        x_bi  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        y1   = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                y1 = y_bo;
            end
        end
        check("busy_start_dones", dcnt, 1);
        check("busy_start_y",     y1,   64000);

        // Reset mid-operation abandons the computation
        @(negedge clk);
        start = 1'b1;
        x_bi  = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_dones", dcnt, 0);
        check("midrst_y",     y_bo, 0);
        check("midrst_busy",  {31'd0, busy}, 0);
        do_cube(8'd2, 24'd8, "x2", 1'b0);

        // Reset and start together: reset wins
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        x_bi  = 8'd9;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        x_bi  = 8'd5;
        @(negedge clk);               // first accept has happened
        x_bi  = 8'd6;
        cyc  = 0;
        dcnt = 0;
        d1   = 0;
        d2   = 0;
        y2   = '0;
        y1   = '0;
        while (dcnt < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    d1 = cyc;
                    y1 = y_bo;
                end else begin
                    d2 = cyc;
                    y2 = y_bo;
                    start = 1'b0;     // drop before the next accepting edge
                end
            end
        end
        start = 1'b0;
        check("b2b_first_lat", d1, 17);
        check("b2b_spacing",   d2 - d1, 18);
        check("b2b_y1",        y1, 125);
        check("b2b_y2",        y2, 216);
        repeat (20) @(negedge clk);
        check("b2b_idle", {31'd0, busy}, 0);

        // Closed-loop sweep: cube then root must return the operand
        for (int v = 0; v <= 40; v++)
            do_cube(8'(v), 24'(v * v * v), $sformatf("loop%0d", v), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cube_calc

`default_nettype wire
